// File: rtl/uart_tx_tick.sv
// UART transmitter driven by an external bit-period strobe.
// Bytes are queued in a small FIFO and sent as 8-bit async frames.
module uart_tx_tick #(
  parameter int CFifoAddrW = 2,
  parameter bit CParityEn  = 1'b0,
  parameter bit CParityOdd = 1'b0,
  parameter int CStopBits  = 1
) (
  input  logic       AClkH,
  input  logic       AResetHN,
  input  logic       AClkHEn,
  input  logic       ABitTick,
  input  logic [7:0] AData,
  input  logic       AWrStrb,
  input  logic       AOvfClr,
  output logic       ATxd,
  output logic       AFull,
  output logic       AEmpty,
  output logic       ABusy,
  output logic       ATxDone,
  output logic       AOverflow
);

  localparam int Depth = 1 << CFifoAddrW;
  localparam logic [CFifoAddrW:0] DepthC = Depth[CFifoAddrW:0];

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
    Parity,
    Stop
  } state_t;

  state_t state;

  logic [7:0]            mem [Depth];
  logic [CFifoAddrW-1:0] wr_ptr;
  logic [CFifoAddrW-1:0] rd_ptr;
  logic [CFifoAddrW:0]   count;
  logic [CFifoAddrW:0]   count_n;

  logic [7:0] shift;
  logic [7:0] head;
  logic [2:0] idx;
  logic       par;
  logic       stop_cnt;

  logic tick;
  logic stop_last;
  logic pop;
  logic push;
  logic drop;

  assign tick      = AClkHEn & ABitTick;
  assign stop_last = (state == Stop) &&
                     (stop_cnt == 1'(CStopBits - 1));
  assign pop       = tick & ~AEmpty &
                     ((state == Idle) | stop_last);
  assign push      = AClkHEn & AWrStrb & (~AFull | pop);
  assign drop      = AClkHEn & AWrStrb & AFull & ~pop;
  assign head      = mem[rd_ptr];
  assign ABusy     = (state != Idle);

  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + 1'b1;
    end else if (pop && !push) begin
      count_n = count - 1'b1;
    end
  end

  always_ff @(posedge AClkH) begin
    if (push) begin
      mem[wr_ptr] <= AData;
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      AFull     <= 1'b0;
      AEmpty    <= 1'b1;
      AOverflow <= 1'b0;
    end else if (AClkHEn) begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_n;
      AFull  <= (count_n == DepthC);
      AEmpty <= (count_n == '0);
      // a drop in the same cycle as a clear keeps the flag set
      if (drop) begin
        AOverflow <= 1'b1;
      end else if (AOvfClr) begin
        AOverflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state    <= Idle;
      ATxd     <= 1'b1;
      ATxDone  <= 1'b0;
      shift    <= '0;
      idx      <= '0;
      par      <= 1'b0;
      stop_cnt <= 1'b0;
    end else if (AClkHEn) begin
      ATxDone <= 1'b0;
      if (ABitTick) begin
        unique case (state)
          Idle: begin
            if (pop) begin
              shift <= head;
              par   <= (^head) ^ CParityOdd;
              ATxd  <= 1'b0;
              state <= Start;
            end
          end
          Start: begin
            ATxd  <= shift[0];
            idx   <= '0;
            state <= Data;
          end
          Data: begin
            if (idx == 3'd7) begin
              if (CParityEn) begin
                ATxd  <= par;
                state <= Parity;
              end else begin
                ATxd     <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= Stop;
              end
            end else begin
              shift <= {1'b0, shift[7:1]};
              ATxd  <= shift[1];
              idx   <= idx + 3'd1;
            end
          end
          Parity: begin
            ATxd     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= Stop;
          end
          Stop: begin
            if (stop_last) begin
              ATxDone <= 1'b1;
              // back-to-back: next start bit follows the last stop bit
              if (pop) begin
                shift <= head;
                par   <= (^head) ^ CParityOdd;
                ATxd  <= 1'b0;
                state <= Start;
              end else begin
                ATxd  <= 1'b1;
                state <= Idle;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            ATxd  <= 1'b1;
            state <= Idle;
          end
        endcase
      end
    end
  end

endmodule
